// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the fifo write arbiter.
// Optional feature macro: FIFO_ARB_LOCK_EN (burst lock FSM).
`ifndef FIFO_ARB_PKG_SV
`define FIFO_ARB_PKG_SV

// Field slicing of a {src_id, payload} fifo word.
`define FIFO_ARB_TAG(dl, sw) (dl) +: (sw)
`define FIFO_ARB_PAY(dl) 0 +: (dl)

package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2_req(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/fifo_wr_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
// Grants the first requester above ptr, wrapping at N.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2_req(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic [IDW-1:0] idx;

    // scan from farthest to nearest so the nearest requester wins
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one fifo write port.
// Optional macro FIFO_ARB_LOCK_EN keeps bursts contiguous.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_LEN   = 32,
    parameter int AddR_Width = 6,
    parameter int SRC_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_wen,
    output logic [SRC_W+DATA_LEN-1:0]   fifo_wdata,
    input  logic                        cons_pop,
    output logic                        fifo_ren,
    output logic [AddR_Width:0]         level,
    output logic                        full,
    output logic                        empty
);

    localparam int LW    = AddR_Width + 1;
    localparam int DEPTH = 2 ** AddR_Width;
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    gnt_id;
    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  gnt;
    logic [DATA_LEN-1:0] pay;
    logic                space;
    logic                accept;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (SRC_W)
    ) u_rr (
        .req    (arb_req),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign full     = (level == LVL_MAX);
    assign empty    = (level == '0);
    assign fifo_ren = ~rst & cons_pop & ~empty;
    assign space    = ~full | fifo_ren;

    assign req_ready = (rst | ~space) ? '0 : gnt;
    assign fifo_wen  = |(req_valid & req_ready);
    assign accept    = fifo_wen;

    // payload mux driven by the one-hot grant
    always_comb begin
        pay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) pay = req_data[i*DATA_LEN +: DATA_LEN];
        end
    end

    assign fifo_wdata[`FIFO_ARB_TAG(DATA_LEN, SRC_W)] = gnt_id;
    assign fifo_wdata[`FIFO_ARB_PAY(DATA_LEN)]        = pay;

`ifdef FIFO_ARB_LOCK_EN
    arb_state_e       state;
    arb_state_e       state_nx;
    logic [SRC_W-1:0] lock_id;
    logic [SRC_W-1:0] lock_id_nx;
    logic             gnt_last;

    assign gnt_last = |(req_last & gnt);
    assign arb_req  = (state == ARB_LOCKED)
                    ? (req_valid & (NUM_REQ'(1) << lock_id))
                    : req_valid;

    // lock state and owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            lock_id <= '0;
        end else begin
            state   <= state_nx;
            lock_id <= lock_id_nx;
        end
    end

    // open a lock on a non-final beat, release it on the final one
    always_comb begin
        state_nx   = state;
        lock_id_nx = lock_id;
        unique case (state)
            ARB_IDLE: begin
                if (accept && !gnt_last) begin
                    state_nx   = ARB_LOCKED;
                    lock_id_nx = gnt_id;
                end
            end
            ARB_LOCKED: begin
                if (accept && gnt_last) state_nx = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign arb_req     = req_valid;
`endif

    // pointer follows the last accepted requester
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= SRC_W'(NUM_REQ - 1);
        end else if (accept) begin
            rr_ptr <= gnt_id;
        end
    end

    // occupancy tracks writes minus pops
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (fifo_wen && !fifo_ren) begin
            level <= level + 1'b1;
        end else if (!fifo_wen && fifo_ren) begin
            level <= level - 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a queue-level reference model.
// Build with +define+FIFO_ARB_LOCK_EN to check the burst-lock variant.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int DL    = 32;
    localparam int AW    = 6;
    localparam int SW    = 2;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DL-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              fifo_wen;
    logic [SW+DL-1:0]  fifo_wdata;
    logic              cons_pop;
    logic              fifo_ren;
    logic [AW:0]       level;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_LEN   (DL),
        .AddR_Width (AW),
        .SRC_W      (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .cons_pop   (cons_pop),
        .fifo_ren   (fifo_ren),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    typedef struct {
        logic [N-1:0]     rdy;
        logic             wen;
        logic             ren;
        logic [SW+DL-1:0] wd;
        int               lvl;
    } exp_t;

    exp_t sb[$];
    int   tags[$];
    bit   cap = 0;
    int   tests = 0;
    int   fails = 0;

    int m_lvl = 0;
    int m_last = N - 1;
    int m_locked = 0;
    int m_lock = 0;
    int m_g = -1;
    bit m_acc = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        if (m_locked != 0) return v[m_lock] ? m_lock : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input logic [N-1:0] v,
                        input logic [N-1:0] l, input bit p);
        exp_t e;
        bit   sp;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_last  = l;
        cons_pop  = p;
        for (int i = 0; i < N; i++) req_data[i*DL +: DL] = $urandom;
        e.lvl = m_lvl;
        e.rdy = '0;
        e.wen = 1'b0;
        e.ren = 1'b0;
        e.wd  = '0;
        m_g   = -1;
        m_acc = 0;
        if (r) begin
            m_lvl    = 0;
            m_last   = N - 1;
            m_locked = 0;
        end else begin
            m_g   = pick(v);
            e.ren = p && (m_lvl > 0);
            sp    = (m_lvl < DEPTH) || e.ren;
            m_acc = (m_g >= 0) && sp;
            if (m_acc) begin
                e.rdy[m_g] = 1'b1;
                e.wen      = 1'b1;
                e.wd       = {SW'(m_g), req_data[m_g*DL +: DL]};
                m_last     = m_g;
`ifdef FIFO_ARB_LOCK_EN
                if (m_locked == 0) begin
                    if (!l[m_g]) begin
                        m_locked = 1;
                        m_lock   = m_g;
                    end
                end else if (l[m_g]) begin
                    m_locked = 0;
                end
`endif
            end
            m_lvl = m_lvl + int'(m_acc) - int'(e.ren);
        end
        sb.push_back(e);
    endtask

    // monitor: compare DUT outputs mid-cycle against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ready", 64'(req_ready), 64'(e.rdy));
                chk("wen", 64'(fifo_wen), 64'(e.wen));
                chk("ren", 64'(fifo_ren), 64'(e.ren));
                chk("level", 64'(level), 64'(e.lvl));
                chk("full", 64'(full), 64'(e.lvl == DEPTH));
                chk("empty", 64'(empty), 64'(e.lvl == 0));
                if (e.wen) chk("wdata", 64'(fifo_wdata), 64'(e.wd));
                if (cap && fifo_wen) tags.push_back(int'(fifo_wdata[SW+DL-1:DL]));
            end
        end
    end

    initial begin
        int n0;
        int exp_tags[$];
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        cons_pop  = 1'b0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        #1;
        chk("rst_level", 64'(level), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_ready", 64'(req_ready), 0);

        // all requesters streaming until full
        for (int i = 0; i < DEPTH; i++) step(0, 4'hF, 4'hF, 0);
        step(0, 4'hF, 4'hF, 0);
        #1;
        chk("t1_full", 64'(full), 1);
        chk("t1_level", 64'(level), 64);
        chk("t1_ready", 64'(req_ready), 0);

        // write while full with a simultaneous pop
        step(0, 4'b0100, 4'hF, 1);
        #1;
        chk("t2_ren", 64'(fifo_ren), 1);
        chk("t2_wen", 64'(fifo_wen), 1);
        chk("t2_tag", 64'(fifo_wdata[SW+DL-1:DL]), 2);
        step(0, 0, 0, 0);
        #1;
        chk("t2_level", 64'(level), 64);

        // drain, then pop while empty
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            #1;
            chk("t3_ren", 64'(fifo_ren), 0);
            chk("t3_empty", 64'(empty), 1);
        end

        // single requester back to back
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0010, 4'hF, 0);
            #1;
            chk("t4_ready", 64'(req_ready), 64'b0010);
        end

        // req 0 three-beat burst against an always-valid req 3
        step(1, 0, 0, 0);
        cap = 1;
        n0  = 3;
        for (int i = 0; i < 8; i++) begin
            step(0, {1'b1, 2'b00, n0 > 0}, {1'b1, 2'b00, n0 == 1}, 0);
            if (m_acc && m_g == 0) n0--;
        end
        @(negedge clk);
        #1;
        cap = 0;
`ifdef FIFO_ARB_LOCK_EN
        exp_tags = '{0, 0, 0, 3};
`else
        exp_tags = '{0, 3, 0, 3, 0};
`endif
        chk("t5_count", 64'(tags.size() >= exp_tags.size()), 1);
        for (int i = 0; i < exp_tags.size() && i < tags.size(); i++)
            chk("t5_order", 64'(tags[i]), 64'(exp_tags[i]));

        // reset mid-stream at level 10
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 4'b0001, 4'hF, 0);
        step(0, 0, 0, 0);
        #1;
        chk("t6_level10", 64'(level), 10);
        step(1, 4'hF, 4'hF, 1);
        step(0, 4'b1010, 4'hF, 0);
        #1;
        chk("t6_level", 64'(level), 0);
        chk("t6_empty", 64'(empty), 1);
        chk("t6_grant", 64'(req_ready), 64'b0010);

        // random traffic with varying pop pressure
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 250; i++) begin
                step($urandom_range(0, 199) == 0, N'($urandom), N'($urandom),
                     $urandom_range(0, 99) < seg * 20);
            end
        end

        step(0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
